// File: rtl/tl_pkg.sv
// Shared TileLink definitions: channel opcodes and width helpers used by the
// burst fragmenter and its support blocks.
package tl_pkg;

  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    ARITHMETIC_DATA  = 3'd2,
    LOGICAL_DATA     = 3'd3,
    GET              = 3'd4,
    INTENT           = 3'd5
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1,
    HINT_ACK        = 3'd2
  } d_opcode_e;

  // log2 of the number of bytes in one beat
  function automatic int lbb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Width able to hold the largest fragment count 2^(max_size-lbb)
  function automatic int cnt_w_of(input int max_size, input int lbb);
    return (max_size > lbb) ? (max_size - lbb + 1) : 1;
  endfunction

endpackage

// File: rtl/tl_burst_fragmenter_if.sv
// One TileLink link (A request + D response). The master drives A and
// receives D; the slave is the mirror image.
interface tl_burst_fragmenter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 2
);
  localparam int BB = DATA_W / 8;

  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [BB-1:0]     a_mask;
  logic [DATA_W-1:0] a_data;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic              d_corrupt;
  logic [DATA_W-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data,
    input  d_ready
  );

endinterface

// File: rtl/tl_dq_fifo.sv
// Small ring-buffer FIFO for D-channel beats. push_ready is simply !full, so a
// full FIFO refuses a push even in a cycle where it also pops.
module tl_dq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ready = (count != CNTW'(DEPTH));
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid & push_ready;
  assign pop        = pop_ready & pop_valid;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an empty count makes stale
  // contents unobservable, and leaving it out of reset keeps it plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tl_burst_fragmenter.sv
// Splits TL-UH bursts wider than one beat into single-beat TL-UL requests and
// merges the resulting D responses back into what the requester expects.
module tl_burst_fragmenter
  import tl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SRC_W    = 2,
  parameter int MAX_SIZE = 6,
  parameter int DQ_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  tl_burst_fragmenter_if.slave  up,
  tl_burst_fragmenter_if.master dn,
  output logic                  err_unsupported
);

  localparam int BB   = DATA_W / 8;
  localparam int LBB  = lbb_of(DATA_W);
  localparam int CW   = cnt_w_of(MAX_SIZE, LBB);
  localparam int NSRC = 1 << SRC_W;
  localparam int DW   = 3 + 3 + SRC_W + 2 + DATA_W;

  // Held low through reset and for the first edge after it, so nothing is
  // forwarded while reset is asserted.
  logic run_q;
  logic err_q;

  logic [CW-1:0] frag_idx;
  logic [2:0]    tbl_size [NSRC];
  logic [CW-1:0] tbl_rem  [NSRC];
  logic          tbl_den  [NSRC];

  logic          big;
  logic          is_get;
  logic          is_put;
  logic          is_amo_hint;
  logic          is_split;
  logic          stall;
  logic          frag_last;
  logic          a_out_fire;
  logic          a_in_fire;
  logic          rec;
  logic [CW-1:0] frag_n;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch can be inferred.
  always_comb begin
    big         = up.a_size > 3'(LBB);
    is_get      = (up.a_opcode == GET);
    is_put      = (up.a_opcode == PUT_FULL_DATA) || (up.a_opcode == PUT_PARTIAL_DATA);
    is_amo_hint = (up.a_opcode == ARITHMETIC_DATA) || (up.a_opcode == LOGICAL_DATA) ||
                  (up.a_opcode == INTENT);
    is_split    = big & (is_get | is_put);
    frag_n      = big ? (CW'(1) << (up.a_size - 3'(LBB))) : CW'(1);
    frag_last   = (frag_idx == frag_n - CW'(1));
    // A source with acks still owed is only blocked between bursts; the burst
    // that created the entry must keep flowing.
    stall       = !run_q || ((frag_idx == '0) && (tbl_rem[up.a_source] != '0));

    dn.a_valid   = up.a_valid & !stall;
    dn.a_opcode  = up.a_opcode;
    dn.a_param   = up.a_param;
    dn.a_size    = up.a_size;
    dn.a_source  = up.a_source;
    dn.a_address = up.a_address;
    dn.a_mask    = up.a_mask;
    dn.a_data    = up.a_data;
    if (is_split) begin
      dn.a_size    = 3'(LBB);
      dn.a_address = up.a_address + (ADDR_W'(frag_idx) << LBB);
      dn.a_mask    = is_get ? {BB{1'b1}} : up.a_mask;
    end

    // A split Get holds its single upstream beat until the last fragment goes.
    up.a_ready = dn.a_ready & !stall & (!(is_split & is_get) | frag_last);
    a_out_fire = dn.a_valid & dn.a_ready;
    a_in_fire  = up.a_valid & up.a_ready;
    rec        = a_out_fire & is_split & (frag_idx == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      frag_idx <= '0;
    end else begin
      run_q <= 1'b1;
      if (a_in_fire && big && is_amo_hint) err_q <= 1'b1;
      if (a_out_fire && is_split) frag_idx <= frag_last ? '0 : frag_idx + CW'(1);
    end
  end

  assign err_unsupported = err_q;

  // D response path
  logic [DW-1:0]      d_in_packed;
  logic [DW-1:0]      head_packed;
  logic               head_valid;
  logic               d_in_ready;
  logic [2:0]         h_opcode;
  logic [2:0]         h_size;
  logic [SRC_W-1:0]   h_source;
  logic               h_denied;
  logic               h_corrupt;
  logic [DATA_W-1:0]  h_data;
  logic [CW-1:0]      h_rem;
  logic               h_split;
  logic               h_is_ack;
  logic               drop;
  logic               pop;
  logic               consume;

  assign d_in_packed = {dn.d_opcode, dn.d_size, dn.d_source, dn.d_denied, dn.d_corrupt, dn.d_data};
  assign dn.d_ready  = d_in_ready;
  assign {h_opcode, h_size, h_source, h_denied, h_corrupt, h_data} = head_packed;

  tl_dq_fifo #(
    .WIDTH (DW),
    .DEPTH (DQ_DEPTH)
  ) u_dq_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_valid (dn.d_valid),
    .push_ready (d_in_ready),
    .push_data  (d_in_packed),
    .pop_valid  (head_valid),
    .pop_ready  (pop),
    .pop_data   (head_packed)
  );

  always_comb begin
    h_rem    = tbl_rem[h_source];
    h_split  = (h_rem != '0);
    h_is_ack = (h_opcode == ACCESS_ACK);
    // Split Put acks are swallowed until the one that retires the entry.
    drop     = head_valid & h_split & h_is_ack & (h_rem != CW'(1));

    up.d_valid   = head_valid & !drop;
    up.d_opcode  = h_opcode;
    up.d_size    = h_split ? tbl_size[h_source] : h_size;
    up.d_source  = h_source;
    up.d_denied  = (h_split & h_is_ack) ? (tbl_den[h_source] | h_denied) : h_denied;
    up.d_corrupt = h_corrupt;
    up.d_data    = h_data;

    pop     = drop | (up.d_valid & up.d_ready);
    consume = pop & h_split;
  end

  // Per-source bookkeeping: recording and retiring never hit the same source
  // in one cycle, since a source is stalled while it has acks outstanding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSRC; i++) begin
        tbl_size[i] <= '0;
        tbl_rem[i]  <= '0;
        tbl_den[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (rec && (up.a_source == SRC_W'(i))) begin
          tbl_size[i] <= up.a_size;
          tbl_rem[i]  <= frag_n;
          tbl_den[i]  <= 1'b0;
        end else if (consume && (h_source == SRC_W'(i))) begin
          tbl_rem[i]  <= tbl_rem[i] - CW'(1);
          tbl_den[i]  <= tbl_den[i] | h_denied;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_burst_fragmenter.sv
// Directed bench for tl_burst_fragmenter: passthrough, Get/Put splitting,
// A stalls, D FIFO back-pressure, unsupported atomics and mid-burst reset.
module tb_tl_burst_fragmenter;
  import tl_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SRC_W    = 2;
  localparam int MAX_SIZE = 6;
  localparam int DQ_DEPTH = 2;

  logic clock;
  logic reset_n;
  logic err_unsupported;
  int   tests_run    = 0;
  int   tests_failed = 0;

  tl_burst_fragmenter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) up_if ();
  tl_burst_fragmenter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dn_if ();

  tl_burst_fragmenter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SRC_W    (SRC_W),
    .MAX_SIZE (MAX_SIZE),
    .DQ_DEPTH (DQ_DEPTH)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .up              (up_if),
    .dn              (dn_if),
    .err_unsupported (err_unsupported)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    up_if.a_valid   = 1'b1;
    up_if.a_opcode  = op;
    up_if.a_param   = 3'd0;
    up_if.a_size    = size;
    up_if.a_source  = src;
    up_if.a_address = addr;
    up_if.a_mask    = mask;
    up_if.a_data    = data;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                       input logic denied, input logic [31:0] data);
    dn_if.d_valid   = 1'b1;
    dn_if.d_opcode  = op;
    dn_if.d_size    = size;
    dn_if.d_source  = src;
    dn_if.d_denied  = denied;
    dn_if.d_corrupt = 1'b0;
    dn_if.d_data    = data;
  endtask

  // Offer one D beat for a single edge; returns just after the next negedge.
  task automatic push_d(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                        input logic denied, input logic [31:0] data);
    set_d(op, size, src, denied, data);
    @(negedge clock);
    dn_if.d_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset_n = 1'b1;
    up_if.a_valid = 1'b0; up_if.a_opcode = '0; up_if.a_param = '0; up_if.a_size = '0;
    up_if.a_source = '0; up_if.a_address = '0; up_if.a_mask = '0; up_if.a_data = '0;
    up_if.d_ready = 1'b1;
    dn_if.a_ready = 1'b1;
    dn_if.d_valid = 1'b0; dn_if.d_opcode = '0; dn_if.d_size = '0; dn_if.d_source = '0;
    dn_if.d_denied = 1'b0; dn_if.d_corrupt = 1'b0; dn_if.d_data = '0;

    // Reset state, with a request already offered upstream
    #2 reset_n = 1'b0;
    up_if.a_valid = 1'b1;
    @(negedge clock); #1;
    check("rst_a_out_valid", dn_if.a_valid, 0);
    check("rst_a_in_ready", up_if.a_ready, 0);
    check("rst_d_out_valid", up_if.d_valid, 0);
    check("rst_d_in_ready", dn_if.d_ready, 1);
    check("rst_err", err_unsupported, 0);
    up_if.a_valid = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);

    // Single-beat Get passes straight through, ready follows downstream
    drive_a(GET, 3'd2, 2'd1, 32'h40, 4'hF, 32'h0); #1;
    check("pass_valid", dn_if.a_valid, 1);
    check("pass_size", dn_if.a_size, 2);
    check("pass_addr", dn_if.a_address, 32'h40);
    check("pass_ready", up_if.a_ready, 1);
    dn_if.a_ready = 1'b0; #1;
    check("pass_ready_low", up_if.a_ready, 0);
    dn_if.a_ready = 1'b1;
    @(negedge clock); up_if.a_valid = 1'b0;
    push_d(ACCESS_ACK_DATA, 3'd2, 2'd1, 1'b0, 32'hA5A5_0001);
    check("pass_d_valid", up_if.d_valid, 1);
    check("pass_d_size", up_if.d_size, 2);
    check("pass_d_data", up_if.d_data, 32'hA5A5_0001);

    // Get size 4 at 0x100 from source 2 becomes four single-beat Gets
    @(negedge clock);
    drive_a(GET, 3'd4, 2'd2, 32'h100, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("get4_addr%0d", i), dn_if.a_address, 32'h100 + 4 * i);
      check($sformatf("get4_size%0d", i), dn_if.a_size, 2);
      check($sformatf("get4_mask%0d", i), dn_if.a_mask, 4'hF);
      check($sformatf("get4_src%0d", i), dn_if.a_source, 2);
      check($sformatf("get4_in_ready%0d", i), up_if.a_ready, (i == 3));
      @(negedge clock);
    end
    drive_a(GET, 3'd2, 2'd2, 32'h500, 4'hF, 32'h0); #1;
    check("src2_busy_valid", dn_if.a_valid, 0);
    check("src2_busy_ready", up_if.a_ready, 0);
    up_if.a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_d(ACCESS_ACK_DATA, 3'd2, 2'd2, 1'b0, 32'hD000_0000 + k);
      check($sformatf("get4_d_valid%0d", k), up_if.d_valid, 1);
      check($sformatf("get4_d_size%0d", k), up_if.d_size, 4);
      check($sformatf("get4_d_data%0d", k), up_if.d_data, 32'hD000_0000 + k);
    end
    @(negedge clock);
    drive_a(GET, 3'd2, 2'd2, 32'h500, 4'hF, 32'h0); #1;
    check("src2_free_valid", dn_if.a_valid, 1);
    up_if.a_valid = 1'b0;

    // PutFull size 4, second fragment denied: one merged ack at the end
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      drive_a(PUT_FULL_DATA, 3'd4, 2'd1, 32'h200, 4'hF, 32'h1111_1111 * (i + 1)); #1;
      check($sformatf("put_addr%0d", i), dn_if.a_address, 32'h200 + 4 * i);
      check($sformatf("put_size%0d", i), dn_if.a_size, 2);
      check($sformatf("put_data%0d", i), dn_if.a_data, 32'h1111_1111 * (i + 1));
      check($sformatf("put_in_ready%0d", i), up_if.a_ready, 1);
      @(negedge clock);
    end
    up_if.a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_d(ACCESS_ACK, 3'd2, 2'd1, (k == 1), 32'h0);
      if (k < 3) begin
        check($sformatf("put_ack_dropped%0d", k), up_if.d_valid, 0);
      end else begin
        check("put_ack_valid", up_if.d_valid, 1);
        check("put_ack_opcode", up_if.d_opcode, ACCESS_ACK);
        check("put_ack_size", up_if.d_size, 4);
        check("put_ack_denied", up_if.d_denied, 1);
      end
    end

    // Downstream stall on the second fragment of a Get size 3
    @(negedge clock);
    drive_a(GET, 3'd3, 2'd0, 32'h100, 4'hF, 32'h0); #1;
    check("stall_frag0_addr", dn_if.a_address, 32'h100);
    check("stall_frag0_in_ready", up_if.a_ready, 0);
    @(negedge clock);
    dn_if.a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall_hold_addr%0d", c), dn_if.a_address, 32'h104);
      check($sformatf("stall_hold_valid%0d", c), dn_if.a_valid, 1);
      check($sformatf("stall_hold_in_ready%0d", c), up_if.a_ready, 0);
      @(negedge clock);
    end
    dn_if.a_ready = 1'b1; #1;
    check("stall_release_addr", dn_if.a_address, 32'h104);
    check("stall_release_in_ready", up_if.a_ready, 1);
    @(negedge clock); up_if.a_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push_d(ACCESS_ACK_DATA, 3'd2, 2'd0, 1'b0, 32'hC0 + k);
      check($sformatf("stall_d_size%0d", k), up_if.d_size, 3);
      check($sformatf("stall_d_data%0d", k), up_if.d_data, 32'hC0 + k);
    end

    // D FIFO fills at two entries, then drains in order
    @(negedge clock);
    up_if.d_ready = 1'b0;
    set_d(ACCESS_ACK_DATA, 3'd2, 2'd3, 1'b0, 32'hA); #1;
    check("fifo_ready0", dn_if.d_ready, 1);
    @(negedge clock);
    set_d(ACCESS_ACK_DATA, 3'd2, 2'd3, 1'b0, 32'hB); #1;
    check("fifo_ready1", dn_if.d_ready, 1);
    check("fifo_head_a", up_if.d_data, 32'hA);
    @(negedge clock);
    set_d(ACCESS_ACK_DATA, 3'd2, 2'd3, 1'b0, 32'hC); #1;
    check("fifo_full_ready", dn_if.d_ready, 0);
    check("fifo_full_head", up_if.d_data, 32'hA);
    check("fifo_full_size", up_if.d_size, 2);
    @(negedge clock); #1;
    check("fifo_still_full", dn_if.d_ready, 0);
    check("fifo_still_head", up_if.d_data, 32'hA);
    up_if.d_ready = 1'b1; #1;
    check("fifo_pop_a", up_if.d_data, 32'hA);
    check("fifo_pop_no_push", dn_if.d_ready, 0);
    @(negedge clock); #1;
    check("fifo_pop_b", up_if.d_data, 32'hB);
    check("fifo_ready_again", dn_if.d_ready, 1);
    @(negedge clock);
    dn_if.d_valid = 1'b0; #1;
    check("fifo_pop_c_valid", up_if.d_valid, 1);
    check("fifo_pop_c", up_if.d_data, 32'hC);
    @(negedge clock); #1;
    check("fifo_empty", up_if.d_valid, 0);

    // Oversized atomic passes unchanged and flags the sticky error
    @(negedge clock);
    drive_a(ARITHMETIC_DATA, 3'd3, 2'd3, 32'h600, 4'hF, 32'h5); #1;
    check("amo_size", dn_if.a_size, 3);
    check("amo_addr", dn_if.a_address, 32'h600);
    check("amo_in_ready", up_if.a_ready, 1);
    check("amo_err_before", err_unsupported, 0);
    @(negedge clock); #1;
    check("amo_err_set", err_unsupported, 1);
    up_if.a_valid = 1'b0;
    @(negedge clock); #1;
    check("amo_err_sticky", err_unsupported, 1);

    // Reset during fragment 3 of a Get size 5, with a D beat waiting
    @(negedge clock);
    up_if.d_ready = 1'b0;
    set_d(ACCESS_ACK_DATA, 3'd2, 2'd3, 1'b0, 32'hEE);
    drive_a(GET, 3'd5, 2'd1, 32'h300, 4'hF, 32'h0); #1;
    check("rmid_addr0", dn_if.a_address, 32'h300);
    @(negedge clock);
    dn_if.d_valid = 1'b0; #1;
    check("rmid_addr1", dn_if.a_address, 32'h304);
    @(negedge clock); #1;
    check("rmid_addr2", dn_if.a_address, 32'h308);
    check("rmid_d_pending", up_if.d_valid, 1);
    reset_n = 1'b0; #1;
    check("rmid_a_out_valid", dn_if.a_valid, 0);
    check("rmid_a_in_ready", up_if.a_ready, 0);
    check("rmid_d_out_valid", up_if.d_valid, 0);
    check("rmid_d_in_ready", dn_if.d_ready, 1);
    check("rmid_err_clear", err_unsupported, 0);
    up_if.a_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    up_if.d_ready = 1'b1;
    @(negedge clock);
    drive_a(GET, 3'd2, 2'd1, 32'h400, 4'hF, 32'h0); #1;
    check("post_rst_valid", dn_if.a_valid, 1);
    check("post_rst_addr", dn_if.a_address, 32'h400);
    check("post_rst_size", dn_if.a_size, 2);
    check("post_rst_in_ready", up_if.a_ready, 1);
    @(negedge clock);
    up_if.a_valid = 1'b0; #1;
    check("post_rst_no_resume", dn_if.a_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
